sparc_mul_arb_ctl: RTL and testbench



---
 rtl/sparc_mul_arb_ctl.sv | 158 +++++++++++++++
 tb/tb_sparc_mul_arb_ctl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sparc_mul_arb_ctl.sv
// Issue controller for the shared 64x64 multiplier datapath.
// Arbitrates EXU/SPU single-cycle requests, drives operand pick and start
// controls, tracks in-flight ops in a fixed-latency tag pipeline and returns
// result-valid strobes to the owner. Also sequences the SPU accumulator
// (enable, clear, shift) and stalls accumulate ops on read-after-write hazards.
module sparc_mul_arb_ctl #(
    parameter int unsigned MUL_LAT = 5  // issue-to-result latency, legal 2..8
) (
    input  logic rclk,
    input  logic rst,
    input  logic exu_mul_req,
    input  logic spu_mul_req,
    input  logic spu_mul_acc,
    input  logic spu_mul_shf,
    input  logic spu_mul_clr,
    output logic mul_exu_ack,
    output logic mul_spu_ack,
    output logic mul_valid,
    output logic mul_spick,
    output logic mul_acc_actc3,
    output logic mul_acc_reg_enb,
    output logic mul_acc_reg_rst,
    output logic mul_acc_reg_shf,
    output logic mul_exu_data_vld,
    output logic mul_spu_data_vld,
    output logic mul_busy
);

    // Owner of an operation; also used for the round-robin history.
    typedef enum logic {
        OWN_EXU = 1'b0,
        OWN_SPU = 1'b1
    } owner_e;

    // Tag pipeline: bit 0 is the newest stage, bit MUL_LAT-1 the returning one.
    logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0] tag_own_q, tag_own_d;
    logic [MUL_LAT-1:0] tag_acc_q, tag_acc_d;

    owner_e last_grant_q, last_grant_d;
    logic   shf_ret_q, shf_ret_d;   // shifted-out data is presented next cycle
    logic   clr_q, clr_d;           // registered accumulator clear request

    // Combinational intermediates
    logic ret_exu;
    logic ret_spu;
    logic acc_inflight;
    logic spu_acc_type;
    logic exu_elig;
    logic spu_elig;
    logic exu_ack;
    logic spu_ack;
    logic spu_shf_ack;
    logic issue;

    // Returning stage and accumulate hazard detection.
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first so
        // no path can leave it unassigned and infer a latch.
        ret_exu      = 1'b0;
        ret_spu      = 1'b0;
        acc_inflight = 1'b0;

        if (tag_vld_q[MUL_LAT-1]) begin
            if (tag_own_q[MUL_LAT-1] == OWN_SPU) ret_spu = 1'b1;
            else                                 ret_exu = 1'b1;
        end

        // The returning stage is excluded: a dependent acc op may issue in the
        // same cycle its predecessor writes the accumulator.
        for (int i = 0; i < int'(MUL_LAT) - 1; i++) begin
            if (tag_vld_q[i] && (tag_own_q[i] == OWN_SPU) && tag_acc_q[i])
                acc_inflight = 1'b1;
        end
    end

    // Eligibility and round-robin arbitration; at most one ack per cycle.
    always_comb begin
        spu_acc_type = spu_mul_acc | spu_mul_shf;
        exu_elig     = exu_mul_req & ~rst;
        spu_elig     = spu_mul_req & ~rst & ~(spu_acc_type & acc_inflight);
        exu_ack      = 1'b0;
        spu_ack      = 1'b0;

        if (exu_elig && spu_elig) begin
            // On conflict the side that did not win last time goes first.
            if (last_grant_q == OWN_SPU) exu_ack = 1'b1;
            else                         spu_ack = 1'b1;
        end else if (exu_elig) begin
            exu_ack = 1'b1;
        end else if (spu_elig) begin
            spu_ack = 1'b1;
        end

        // Shift takes precedence over accumulate and never uses the multiplier.
        spu_shf_ack = spu_ack & spu_mul_shf;
        issue       = (exu_ack | spu_ack) & ~spu_shf_ack;
    end

    // Next-state for the tag pipeline and the small control registers.
    always_comb begin
        tag_vld_d    = {tag_vld_q[MUL_LAT-2:0], issue};
        tag_own_d    = {tag_own_q[MUL_LAT-2:0], spu_ack};
        tag_acc_d    = {tag_acc_q[MUL_LAT-2:0], spu_ack & spu_mul_acc & ~spu_mul_shf};
        shf_ret_d    = spu_shf_ack;
        clr_d        = spu_mul_clr;
        last_grant_d = last_grant_q;
        if (exu_ack) last_grant_d = OWN_EXU;
        if (spu_ack) last_grant_d = OWN_SPU;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge rclk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
            tag_acc_q    <= '0;
            shf_ret_q    <= 1'b0;
            clr_q        <= 1'b0;
            // EXU wins the first conflict after reset.
            last_grant_q <= OWN_SPU;
        end else begin
            tag_vld_q    <= tag_vld_d;
            tag_own_q    <= tag_own_d;
            tag_acc_q    <= tag_acc_d;
            shf_ret_q    <= shf_ret_d;
            clr_q        <= clr_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output decode; everything is forced quiet while reset is held, except
    // the accumulator clear which is held active.
    always_comb begin
        mul_exu_ack      = exu_ack;
        mul_spu_ack      = spu_ack;
        mul_valid        = issue;
        mul_spick        = spu_ack;
        mul_acc_actc3    = spu_ack & spu_mul_acc & ~spu_mul_shf;
        mul_acc_reg_shf  = spu_shf_ack;
        mul_acc_reg_rst  = rst | clr_q;
        mul_exu_data_vld = 1'b0;
        mul_spu_data_vld = 1'b0;
        mul_acc_reg_enb  = 1'b0;
        mul_busy         = 1'b0;

        if (!rst) begin
            mul_exu_data_vld = ret_exu;
            mul_spu_data_vld = ret_spu | shf_ret_q;
            // A coincident clear wins over a result write into the accumulator.
            mul_acc_reg_enb  = spu_shf_ack | (ret_spu & ~clr_q);
            mul_busy         = (|tag_vld_q) | shf_ret_q;
        end
    end

endmodule

// File: tb/tb_sparc_mul_arb_ctl.sv
// Directed testbench for sparc_mul_arb_ctl with MUL_LAT = 5.
// Each cycle's inputs are driven after the falling edge and all outputs are
// compared 1 ns later against hand-computed vectors.
// Output vector bit order:
//   [10] exu_ack [9] spu_ack [8] valid [7] spick [6] actc3 [5] acc_enb
//   [4] acc_rst [3] acc_shf [2] exu_dv [1] spu_dv [0] busy
module tb_sparc_mul_arb_ctl;

    // Stimulus vector bits: {rst, exu_req, spu_req, acc, shf, clr}
    localparam logic [5:0] R = 6'b100000;
    localparam logic [5:0] E = 6'b010000;
    localparam logic [5:0] S = 6'b001000;
    localparam logic [5:0] A = 6'b000100;
    localparam logic [5:0] H = 6'b000010;
    localparam logic [5:0] C = 6'b000001;
    localparam logic [5:0] I = 6'b000000;

    logic rclk = 1'b0;
    logic rst = 1'b0;
    logic exu_mul_req = 1'b0;
    logic spu_mul_req = 1'b0;
    logic spu_mul_acc = 1'b0;
    logic spu_mul_shf = 1'b0;
    logic spu_mul_clr = 1'b0;
    logic mul_exu_ack, mul_spu_ack, mul_valid, mul_spick, mul_acc_actc3;
    logic mul_acc_reg_enb, mul_acc_reg_rst, mul_acc_reg_shf;
    logic mul_exu_data_vld, mul_spu_data_vld, mul_busy;
    logic [10:0] obs;

    int checks = 0;
    int errors = 0;

    sparc_mul_arb_ctl #(.MUL_LAT(5)) dut (
        .rclk             (rclk),
        .rst              (rst),
        .exu_mul_req      (exu_mul_req),
        .spu_mul_req      (spu_mul_req),
        .spu_mul_acc      (spu_mul_acc),
        .spu_mul_shf      (spu_mul_shf),
        .spu_mul_clr      (spu_mul_clr),
        .mul_exu_ack      (mul_exu_ack),
        .mul_spu_ack      (mul_spu_ack),
        .mul_valid        (mul_valid),
        .mul_spick        (mul_spick),
        .mul_acc_actc3    (mul_acc_actc3),
        .mul_acc_reg_enb  (mul_acc_reg_enb),
        .mul_acc_reg_rst  (mul_acc_reg_rst),
        .mul_acc_reg_shf  (mul_acc_reg_shf),
        .mul_exu_data_vld (mul_exu_data_vld),
        .mul_spu_data_vld (mul_spu_data_vld),
        .mul_busy         (mul_busy)
    );

    always #5 rclk = ~rclk;

    assign obs = {mul_exu_ack, mul_spu_ack, mul_valid, mul_spick, mul_acc_actc3,
                  mul_acc_reg_enb, mul_acc_reg_rst, mul_acc_reg_shf,
                  mul_exu_data_vld, mul_spu_data_vld, mul_busy};

    // Drive one cycle of inputs after the falling edge, settle before sampling.
    task automatic apply(input logic [5:0] v);
        @(negedge rclk);
        {rst, exu_mul_req, spu_mul_req, spu_mul_acc, spu_mul_shf, spu_mul_clr} = v;
        #1;
    endtask

    task automatic do_reset();
        apply(R);
        apply(R);
    endtask

    task automatic test_reset();
        logic [5:0]  st [4];
        logic [10:0] ex [4];
        st = '{R | E | S, R | E | S | A, R, I};
        ex = '{11'h010, 11'h010, 11'h010, 11'h000};
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL reset cyc%0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_exu_alone();
        logic [5:0]  st [7];
        logic [10:0] ex [7];
        do_reset();
        st = '{E, I, I, I, I, I, I};
        ex = '{11'h500, 11'h001, 11'h001, 11'h001, 11'h001, 11'h005, 11'h000};
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL exu_alone cyc%0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_both_alternate();
        logic [5:0]  st [10];
        logic [10:0] ex [10];
        do_reset();
        st = '{E | S, E | S, E | S, E | S, I, I, I, I, I, I};
        ex = '{11'h500, 11'h381, 11'h501, 11'h381, 11'h001,
               11'h005, 11'h023, 11'h005, 11'h023, 11'h000};
        for (int i = 0; i < 10; i++) begin
            apply(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL both_alt cyc%0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_acc_hazard();
        logic [5:0]  st [12];
        logic [10:0] ex [12];
        do_reset();
        st = '{S | A, E | S | A, S | A, S | A, S | A, S | A,
               I, I, I, I, I, I};
        ex = '{11'h3C0, 11'h501, 11'h001, 11'h001, 11'h001, 11'h3E3,
               11'h005, 11'h001, 11'h001, 11'h001, 11'h023, 11'h000};
        for (int i = 0; i < 12; i++) begin
            apply(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL acc_hazard cyc%0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [5:0]  st [8];
        logic [10:0] ex [8];
        do_reset();
        // Plain shift at cycle 3, then shift+acc (shift wins) at cycle 5.
        st = '{I, I, I, S | H, I, S | H | A, I, I};
        ex = '{11'h000, 11'h000, 11'h000, 11'h2A8, 11'h003,
               11'h2A8, 11'h003, 11'h000};
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL shift cyc%0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_clear_vs_write();
        logic [5:0]  st [9];
        logic [10:0] ex [9];
        do_reset();
        st = '{S, I, I, I, C, I, C, I, I};
        ex = '{11'h380, 11'h001, 11'h001, 11'h001, 11'h001,
               11'h013, 11'h000, 11'h010, 11'h000};
        for (int i = 0; i < 9; i++) begin
            apply(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL clear_write cyc%0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [5:0]  st [9];
        logic [10:0] ex [9];
        do_reset();
        // SPU then EXU acked (last grant EXU), reset drops both; the next
        // conflict must still go to EXU and no result strobe may appear.
        st = '{S, E, R | E, I, I, I, I, E | S, I};
        ex = '{11'h380, 11'h501, 11'h010, 11'h000, 11'h000,
               11'h000, 11'h000, 11'h500, 11'h001};
        for (int i = 0; i < 9; i++) begin
            apply(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL reset_midflight cyc%0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exu_alone();
        test_both_alternate();
        test_acc_hazard();
        test_shift();
        test_clear_vs_write();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
